// File: rtl/uart_cmd_parser.sv
// UART command frame parser: HEADER, ID, 4 data bytes (+ checksum when
// UART_CMD_CHECKSUM_EN is defined), with inter-byte timeout resync.
module uart_cmd_parser #(
    parameter int         SYS_CLK_FRE   = 50_000_000,
    parameter int         BPS           = 9600,
    parameter int         TIMEOUT_CHARS = 4,
    parameter logic [7:0] HEADER        = 8'h55
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        rx_byte_valid,
    input  logic [7:0]  rx_byte,
    output logic        cmd_valid,
    output logic [7:0]  cmd_id,
    output logic [31:0] cmd_data,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        busy
);

    localparam int BPS_CNT     = SYS_CLK_FRE / BPS;
    localparam int TIMEOUT_CYC = TIMEOUT_CHARS * 10 * BPS_CNT;
    localparam int CW          = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        DATA,
`ifdef UART_CMD_CHECKSUM_EN
        CSUM,
`endif
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [7:0]    id_q;
    logic [31:0]   shreg;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]    acc;
`endif

    assign busy = (state != IDLE);

    // sys_rst_n is active-high despite its name
    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            id_q      <= '0;
            shreg     <= '0;
            cmd_valid <= 1'b0;
            cmd_id    <= '0;
            cmd_data  <= '0;
            frame_err <= 1'b0;
            err_code  <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            acc       <= '0;
`endif
        end else begin
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rx_byte_valid && rx_byte == HEADER)
                        state <= CMD;
                end
                DONE: begin
                    cnt       <= '0;
                    cmd_valid <= 1'b1;
                    cmd_id    <= id_q;
                    cmd_data  <= shreg;
                    state     <= IDLE;
                end
                default: begin
                    // a byte on the terminal-count cycle takes priority
                    if (rx_byte_valid) begin
                        cnt <= '0;
                        case (state)
                            CMD: begin
                                id_q  <= rx_byte;
                                idx   <= 2'd0;
                                state <= DATA;
`ifdef UART_CMD_CHECKSUM_EN
                                acc   <= rx_byte;
`endif
                            end
                            DATA: begin
                                shreg <= {shreg[23:0], rx_byte};
                                idx   <= idx + 2'd1;
`ifdef UART_CMD_CHECKSUM_EN
                                acc   <= acc + rx_byte;
                                if (idx == 2'd3)
                                    state <= CSUM;
`else
                                if (idx == 2'd3)
                                    state <= DONE;
`endif
                            end
`ifdef UART_CMD_CHECKSUM_EN
                            CSUM: begin
                                if (rx_byte == acc) begin
                                    state <= DONE;
                                end else begin
                                    frame_err <= 1'b1;
                                    err_code  <= 2'b01;
                                    state     <= IDLE;
                                end
                            end
`endif
                            default: state <= IDLE;
                        endcase
                    end else if (cnt == CNT_MAX) begin
                        cnt       <= '0;
                        frame_err <= 1'b1;
                        err_code  <= 2'b10;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomised self-checking bench for uart_cmd_parser against a frame-level
// reference model; follows UART_CMD_CHECKSUM_EN like the design.
module tb_uart_cmd_parser;

    localparam int         TO     = 400;
    localparam logic [7:0] HEADER = 8'h55;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        rx_byte_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        cmd_valid;
    logic [7:0]  cmd_id;
    logic [31:0] cmd_data;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cv_cnt = 0;
    int fe_cnt = 0;
    int exp_cv = 0;
    int exp_fe = 0;
    logic [7:0]  exp_id = 8'h00;
    logic [31:0] exp_data = 32'h0;
    logic [1:0]  exp_err = 2'b00;

    uart_cmd_parser #(
        .SYS_CLK_FRE  (50_000_000),
        .BPS          (5_000_000),
        .TIMEOUT_CHARS(4),
        .HEADER       (HEADER)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .rx_byte_valid(rx_byte_valid),
        .rx_byte      (rx_byte),
        .cmd_valid    (cmd_valid),
        .cmd_id       (cmd_id),
        .cmd_data     (cmd_data),
        .frame_err    (frame_err),
        .err_code     (err_code),
        .busy         (busy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (cmd_valid) cv_cnt <= cv_cnt + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // all tasks start and end 1 time unit after a rising edge
    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte_valid = 1'b1;
        rx_byte = b;
        @(posedge sys_clk);
        #1;
        rx_byte_valid = 1'b0;
        rx_byte = $urandom_range(0, 255);
    endtask

    task automatic check_counts(input string tag);
        idle(3);
        check({tag, "_cv_count"}, cv_cnt, exp_cv);
        check({tag, "_fe_count"}, fe_cnt, exp_fe);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    // kind: 0 good, 1 bad checksum, 2 truncated (times out)
    task automatic send_frame(input logic [7:0] id, input logic [31:0] data,
                              input int kind, input int gap);
        logic [7:0] q[$];
        logic [7:0] sum;
        int n;
        q.push_back(HEADER);
        q.push_back(id);
        for (int i = 3; i >= 0; i--) q.push_back(data[i*8 +: 8]);
        sum = id + data[31:24] + data[23:16] + data[15:8] + data[7:0];
`ifdef UART_CMD_CHECKSUM_EN
        if (kind == 1) sum = sum + 8'($urandom_range(1, 255));
        q.push_back(sum);
`endif
        n = q.size();
        if (kind == 2) n = $urandom_range(1, q.size() - 1);
        for (int i = 0; i < n; i++) begin
            if (i > 0) idle(gap);
            send_byte(q[i]);
        end
        if (kind == 0) begin
            check("good_pre", {31'b0, cmd_valid}, 32'd0);
            idle(1);
            check("good_valid", {31'b0, cmd_valid}, 32'd1);
            check("good_id", {24'b0, cmd_id}, {24'b0, id});
            check("good_data", cmd_data, data);
            check("good_no_err", {31'b0, frame_err}, 32'd0);
            idle(1);
            check("good_one_shot", {31'b0, cmd_valid}, 32'd0);
            exp_cv++;
            exp_id = id;
            exp_data = data;
        end else if (kind == 1) begin
            check("csum_err", {31'b0, frame_err}, 32'd1);
            check("csum_code", {30'b0, err_code}, 32'd1);
            check("csum_busy", {31'b0, busy}, 32'd0);
            exp_fe++;
            exp_err = 2'b01;
        end else begin
            idle(TO - 1);
            check("to_early", {31'b0, frame_err}, 32'd0);
            check("to_busy_hold", {31'b0, busy}, 32'd1);
            idle(1);
            check("to_err", {31'b0, frame_err}, 32'd1);
            check("to_code", {30'b0, err_code}, 32'd2);
            exp_fe++;
            exp_err = 2'b10;
        end
        check_counts("frame");
        check("held_id", {24'b0, cmd_id}, {24'b0, exp_id});
        check("held_data", cmd_data, exp_data);
        check("held_code", {30'b0, err_code}, {30'b0, exp_err});
    endtask

    initial begin
        int kind;
        sys_rst_n = 1'b1;
        idle(3);
        check("rst_cv", {31'b0, cmd_valid}, 32'd0);
        check("rst_id", {24'b0, cmd_id}, 32'd0);
        check("rst_data", cmd_data, 32'd0);
        check("rst_fe", {31'b0, frame_err}, 32'd0);
        check("rst_code", {30'b0, err_code}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        sys_rst_n = 1'b0;
        idle(2);

        send_frame(8'h01, 32'h12345678, 0, 99);
`ifdef UART_CMD_CHECKSUM_EN
        send_frame(8'h01, 32'h12345678, 1, 99);
        send_frame(8'h01, 32'h12345678, 0, 99);
`endif
        send_byte(8'hAA);
        idle(99);
        send_byte(8'h00);
        idle(99);
        check("junk_idle", {31'b0, busy}, 32'd0);
        send_frame(8'h02, 32'h000000FF, 0, 99);

        send_byte(HEADER);
        idle(99);
        send_byte(8'h03);
        idle(TO - 1);
        check("to3_early", {31'b0, frame_err}, 32'd0);
        idle(1);
        check("to3_err", {31'b0, frame_err}, 32'd1);
        check("to3_code", {30'b0, err_code}, 32'd2);
        exp_fe++;
        exp_err = 2'b10;
        check_counts("to3");
        send_frame(8'h05, 32'hDEADBEEF, 0, 99);

        // byte on terminal count is taken, not timed out
        send_frame(8'h07, 32'hCAFEF00D, 0, TO - 1);
        send_frame(8'h55, 32'h55555555, 0, 0);

        send_byte(HEADER);
        idle(99);
        send_byte(8'h04);
        idle(99);
        send_byte(8'h12);
        idle(10);
        sys_rst_n = 1'b1;
        idle(1);
        sys_rst_n = 1'b0;
        exp_id = 8'h00;
        exp_data = 32'h0;
        exp_err = 2'b00;
        check("mid_rst_id", {24'b0, cmd_id}, 32'd0);
        check("mid_rst_data", cmd_data, 32'd0);
        check("mid_rst_code", {30'b0, err_code}, 32'd0);
        idle(TO + 20);
        check_counts("mid_rst");
        send_frame(8'h05, 32'hDEADBEEF, 0, 99);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                logic [7:0] j;
                j = $urandom_range(0, 255);
                if (j == HEADER) j = 8'hAA;
                send_byte(j);
                idle($urandom_range(0, 50));
            end
`ifdef UART_CMD_CHECKSUM_EN
            kind = $urandom_range(0, 2);
`else
            kind = ($urandom_range(0, 2) == 2) ? 2 : 0;
`endif
            send_frame($urandom_range(0, 255), $urandom, kind,
                       $urandom_range(0, 120));
        end

        check("final_cv_count", cv_cnt, exp_cv);
        check("final_fe_count", fe_cnt, exp_fe);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
